// File: rtl/event_frame_tx.sv
// Serializes a LENGTH-bit word onto LINES serial lines. Each line carries a start bit,
// W data bits sent MSB first and an even-parity bit, followed by a GAP-cycle idle gap.
module event_frame_tx #(
    parameter int LENGTH = 128,
    parameter int LINES  = 3,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic [LENGTH-1:0] data_in,
    output logic [LINES-1:0]  d,
    output logic              idle,
    output logic [31:0]       frames_sent
);

    localparam int W    = (LENGTH + LINES - 1) / LINES;
    localparam int CMAX = (W > GAP) ? W : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    logic [2:0]         r_state;
    logic [W-1:0]       r_sh [LINES];
    logic [LINES-1:0]   r_par;
    logic [CW-1:0]      r_cnt;
    logic [LINES-1:0]   r_d;
    logic [31:0]        r_frames;

    logic [LINES*W-1:0] w_pad;
    logic [LINES-1:0]   w_par;
    logic [LINES-1:0]   w_msb;

    // Parity is taken from the padded word at accept so no running accumulator is needed.
    always_comb begin
        w_pad = '0;
        w_pad[LENGTH-1:0] = data_in;
        for (int unsigned j = 0; j < LINES; j++) begin
            w_par[j] = ^w_pad[j*W +: W];
            w_msb[j] = r_sh[j][W-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_par    <= '0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_frames <= '0;
            for (int unsigned j = 0; j < LINES; j++) begin
                r_sh[j] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_d <= '0;
                    if (valid) begin
                        for (int unsigned j = 0; j < LINES; j++) begin
                            r_sh[j] <= w_pad[j*W +: W];
                        end
                        r_par   <= w_par;
                        r_d     <= '1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_d <= w_msb;
                    for (int unsigned j = 0; j < LINES; j++) begin
                        r_sh[j] <= {r_sh[j][W-2:0], 1'b0};
                    end
                    r_cnt   <= CW'(1);
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    // r_cnt holds the number of data bits already placed on d.
                    if (r_cnt == CW'(W)) begin
                        r_d     <= r_par;
                        r_state <= S_PARITY;
                    end else begin
                        r_d <= w_msb;
                        for (int unsigned j = 0; j < LINES; j++) begin
                            r_sh[j] <= {r_sh[j][W-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    r_d      <= '0;
                    r_frames <= r_frames + 32'd1;
                    if (GAP > 1) begin
                        r_cnt   <= CW'(1);
                        r_state <= S_GAP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    r_d <= '0;
                    if (r_cnt >= CW'(GAP - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_d     <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign idle        = (r_state == S_IDLE);
    assign d           = r_d;
    assign frames_sent = r_frames;

endmodule
